// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath slice: R1-R3, PC, IR, MAR, MDR, Y and Zlow on one bus with a small ALU.
// Optional macro DATAPATH_ROR_EN adds the ROR input and a rotate-right ALU operation.
module data_path #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             MD_read,
  input  logic             MDRin,
  input  logic             MARin,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             Zlowin,
  input  logic             R1in,
  input  logic             R2in,
  input  logic             R3in,
  input  logic             R1out,
  input  logic             R2out,
  input  logic             R3out,
  input  logic             PCout,
  input  logic             MDRout,
  input  logic             Zlowout,
  input  logic             IncPC,
`ifdef DATAPATH_ROR_EN
  input  logic             ROR,
`endif
  input  logic             ROL,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] R1_q,
  output logic [WIDTH-1:0] R2_q,
  output logic [WIDTH-1:0] R3_q,
  output logic [WIDTH-1:0] PC_q,
  output logic [WIDTH-1:0] IR_q,
  output logic [WIDTH-1:0] MAR_q,
  output logic [WIDTH-1:0] MDR_q,
  output logic [WIDTH-1:0] Zlow_q
);

  logic [WIDTH-1:0] Y_q;
  logic [WIDTH-1:0] alu_d;
  logic [WIDTH-1:0] R1_d, R2_d, R3_d, PC_d, IR_d, MAR_d, MDR_d, Y_d, Zlow_d;

  // Rotates via a doubled word so no bits fall off either end.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] a, input logic [4:0] n);
    logic [2*WIDTH-1:0] d;
    d = {a, a} << n;
    return d[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] a, input logic [4:0] n);
    logic [2*WIDTH-1:0] d;
    d = {a, a} >> n;
    return d[WIDTH-1:0];
  endfunction

  always_comb begin
    BusMuxOut = '0;
    if      (MDRout)  BusMuxOut = MDR_q;
    else if (Zlowout) BusMuxOut = Zlow_q;
    else if (PCout)   BusMuxOut = PC_q;
    else if (R1out)   BusMuxOut = R1_q;
    else if (R2out)   BusMuxOut = R2_q;
    else if (R3out)   BusMuxOut = R3_q;
  end

  always_comb begin
    alu_d = Y_q + BusMuxOut;
    if      (IncPC) alu_d = BusMuxOut + WIDTH'(1);
    else if (ROL)   alu_d = rotl(Y_q, BusMuxOut[4:0]);
`ifdef DATAPATH_ROR_EN
    else if (ROR)   alu_d = rotr(Y_q, BusMuxOut[4:0]);
`else
    else            alu_d = Y_q + BusMuxOut;
`endif
  end

`ifndef DATAPATH_ROR_EN
  // rotr stays declared so both builds share one function set; keep it referenced.
  logic [WIDTH-1:0] rotr_unused;
  assign rotr_unused = rotr(Y_q, 5'd0) ^ Y_q;
  logic unused_ok;
  assign unused_ok = &{1'b0, rotr_unused};
`endif

  always_comb begin
    R1_d   = R1in   ? BusMuxOut : R1_q;
    R2_d   = R2in   ? BusMuxOut : R2_q;
    R3_d   = R3in   ? BusMuxOut : R3_q;
    PC_d   = PCin   ? BusMuxOut : PC_q;
    IR_d   = IRin   ? BusMuxOut : IR_q;
    MAR_d  = MARin  ? BusMuxOut : MAR_q;
    Y_d    = Yin    ? BusMuxOut : Y_q;
    Zlow_d = Zlowin ? alu_d     : Zlow_q;
    MDR_d  = MDRin  ? (MD_read ? Mdatain : BusMuxOut) : MDR_q;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      R1_q   <= '0;
      R2_q   <= '0;
      R3_q   <= '0;
      PC_q   <= '0;
      IR_q   <= '0;
      MAR_q  <= '0;
      MDR_q  <= '0;
      Y_q    <= '0;
      Zlow_q <= '0;
    end else begin
      R1_q   <= R1_d;
      R2_q   <= R2_d;
      R3_q   <= R3_d;
      PC_q   <= PC_d;
      IR_q   <= IR_d;
      MAR_q  <= MAR_d;
      MDR_q  <= MDR_d;
      Y_q    <= Y_d;
      Zlow_q <= Zlow_d;
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed micro-step sequences plus random strobes against a behavioural model.
module tb_data_path;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain;
  logic        MD_read, MDRin, MARin, PCin, IRin, Yin, Zlowin;
  logic        R1in, R2in, R3in, R1out, R2out, R3out, PCout, MDRout, Zlowout;
  logic        IncPC, ROL;
  logic        ROR_s;
  logic [31:0] BusMuxOut, R1_q, R2_q, R3_q, PC_q, IR_q, MAR_q, MDR_q, Zlow_q;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_r1, m_r2, m_r3, m_pc, m_ir, m_mar, m_mdr, m_y, m_z;

  always #5 clock = ~clock;

  data_path #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .MD_read(MD_read),
    .MDRin(MDRin), .MARin(MARin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
    .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .R1out(R1out), .R2out(R2out), .R3out(R3out), .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout),
    .IncPC(IncPC),
`ifdef DATAPATH_ROR_EN
    .ROR(ROR_s),
`endif
    .ROL(ROL),
    .BusMuxOut(BusMuxOut), .R1_q(R1_q), .R2_q(R2_q), .R3_q(R3_q), .PC_q(PC_q),
    .IR_q(IR_q), .MAR_q(MAR_q), .MDR_q(MDR_q), .Zlow_q(Zlow_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rot_left(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = a;
    for (int i = 0; i < n; i++) v = {v[30:0], v[31]};
    return v;
  endfunction

  function automatic logic [31:0] m_bus();
    if (MDRout)  return m_mdr;
    if (Zlowout) return m_z;
    if (PCout)   return m_pc;
    if (R1out)   return m_r1;
    if (R2out)   return m_r2;
    if (R3out)   return m_r3;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_alu(input logic [31:0] b);
    if (IncPC) return b + 32'd1;
    if (ROL)   return rot_left(m_y, b % 32);
    return m_y + b;
  endfunction

  task automatic m_reset();
    {m_r1, m_r2, m_r3, m_pc, m_ir, m_mar, m_mdr, m_y, m_z} = '0;
  endtask

  task automatic idle();
    {MD_read, MDRin, MARin, PCin, IRin, Yin, Zlowin} = '0;
    {R1in, R2in, R3in, R1out, R2out, R3out, PCout, MDRout, Zlowout} = '0;
    {IncPC, ROL} = '0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".R1"}, R1_q, m_r1);
    chk({tag, ".R2"}, R2_q, m_r2);
    chk({tag, ".R3"}, R3_q, m_r3);
    chk({tag, ".PC"}, PC_q, m_pc);
    chk({tag, ".IR"}, IR_q, m_ir);
    chk({tag, ".MAR"}, MAR_q, m_mar);
    chk({tag, ".MDR"}, MDR_q, m_mdr);
    chk({tag, ".Z"}, Zlow_q, m_z);
  endtask

  // Inputs are already driven; check the bus, clock one edge, check every register, then idle.
  task automatic step(input string tag);
    logic [31:0] b, a;
    #1;
    b = m_bus();
    a = m_alu(b);
    chk({tag, ".bus"}, BusMuxOut, b);
    if (R1in)   m_r1  = b;
    if (R2in)   m_r2  = b;
    if (R3in)   m_r3  = b;
    if (PCin)   m_pc  = b;
    if (IRin)   m_ir  = b;
    if (MARin)  m_mar = b;
    if (Yin)    m_y   = b;
    if (Zlowin) m_z   = a;
    if (MDRin)  m_mdr = MD_read ? Mdatain : b;
    @(posedge clock);
    #1;
    chk_regs(tag);
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v, input string tag);
    Mdatain = v; MD_read = 1'b1; MDRin = 1'b1;
    step(tag);
  endtask

  initial begin
    ROR_s = 1'b0;
    Mdatain = '0;
    idle();
    clear = 1'b0;
    m_reset();
    #12;
    chk_regs("reset");
    clear = 1'b1;
    @(posedge clock); #1;

    // register loads through MDR
    load_mdr(32'hF0000012, "ldF0");
    MDRout = 1; R2in = 1; step("r2");
    load_mdr(32'h00000008, "ld08");
    MDRout = 1; R3in = 1; step("r3");
    load_mdr(32'h00000018, "ld18");
    MDRout = 1; R1in = 1; step("r1");
    chk("r2val", R2_q, 32'hF0000012);

    // fetch
    PCout = 1; MARin = 1; IncPC = 1; Zlowin = 1; step("t0");
    Zlowout = 1; PCin = 1; MD_read = 1; MDRin = 1; Mdatain = 32'h0000000C; step("t1");
    MDRout = 1; IRin = 1; step("t2");
    chk("ir", IR_q, 32'h0000000C);
    chk("pc", PC_q, 32'h00000001);

    // ROL execute
    R2out = 1; Yin = 1; step("t3");
    R3out = 1; ROL = 1; Zlowin = 1; step("t4");
    Zlowout = 1; R1in = 1; step("t5");
    chk("rol", R1_q, 32'h000012F0);

    // rotate edges
    load_mdr(32'h80000001, "ld8001");
    MDRout = 1; Yin = 1; step("y8001");
    ROL = 1; Zlowin = 1; step("rot0");
    chk("rot0v", Zlow_q, 32'h80000001);
    PCout = 1; ROL = 1; Zlowin = 1; step("rot1");
    chk("rot1v", Zlow_q, 32'h00000003);
    load_mdr(32'd33, "ld33");
    MDRout = 1; ROL = 1; Zlowin = 1; step("rot33");
    chk("rot33v", Zlow_q, 32'h00000003);

    // add wrap and priority
    load_mdr(32'hFFFFFFFF, "ldFF");
    MDRout = 1; Yin = 1; step("yFF");
    load_mdr(32'h1, "ld1");
    MDRout = 1; Zlowin = 1; step("wrap");
    chk("wrapv", Zlow_q, 32'h0);
    load_mdr(32'h5, "ld5");
    MDRout = 1; IncPC = 1; ROL = 1; Zlowin = 1; step("incrol");
    chk("incrolv", Zlow_q, 32'h6);
    PCout = 1; R1out = 1; #1;
    chk("busprio", BusMuxOut, PC_q);
    step("busprio");

    // same-register read and write
    R1out = 1; R1in = 1; step("r1self");
    Zlowout = 1; Zlowin = 1; IncPC = 1; step("zself");

    // random strobes
    for (int i = 0; i < 300; i++) begin
      Mdatain = $urandom();
      MD_read = 1'($urandom_range(0, 1));
      {MDRin, MARin, PCin, IRin, Yin, Zlowin} = 6'($urandom());
      {R1in, R2in, R3in} = 3'($urandom());
      R1out = ($urandom_range(0, 3) == 0); R2out = ($urandom_range(0, 3) == 0);
      R3out = ($urandom_range(0, 3) == 0); PCout = ($urandom_range(0, 3) == 0);
      MDRout = ($urandom_range(0, 3) == 0); Zlowout = ($urandom_range(0, 3) == 0);
      IncPC = ($urandom_range(0, 3) == 0); ROL = ($urandom_range(0, 2) == 0);
      step("rnd");
    end

    // async reset between edges
    load_mdr(32'hDEADBEEF, "ldDB");
    MDRout = 1; R1in = 1; PCin = 1; step("preclr");
    #2;
    clear = 1'b0;
    m_reset();
    #1;
    chk_regs("async");
    Mdatain = 32'hFFFFFFFF; MD_read = 1; MDRin = 1; PCin = 1; R1in = 1; Zlowin = 1; IncPC = 1;
    repeat (2) @(posedge clock);
    #1;
    chk_regs("hold");
    idle(); PCout = 1; #1;
    chk("clrbus", BusMuxOut, 32'h0);
    idle();
    #2;
    clear = 1'b1;
    @(posedge clock); #1;
    load_mdr(32'h12345678, "resume");
    MDRout = 1; R3in = 1; step("resume2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
